// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: execute-side result channels in, register-file /
// commit writeback ports out. 'master' is the execute/commit side driving
// results and flush; 'slave' is the arbiter.
interface wb_arbiter_if #(
  parameter int IN_CH    = 6,
  parameter int WB_PORTS = 4,
  parameter int PHY_ID_W = 6,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 5
);
  logic                         flush;
  logic [IN_CH-1:0]             in_valid;
  logic [IN_CH-1:0]             in_ready;
  logic [IN_CH-1:0]             in_rd_we;
  logic [IN_CH-1:0]             in_exc;
  logic [IN_CH*PHY_ID_W-1:0]    in_phy_id;
  logic [IN_CH*DATA_W-1:0]      in_data;
  logic [IN_CH*ROB_ID_W-1:0]    in_rob_id;
  logic [WB_PORTS-1:0]          wb_valid;
  logic [WB_PORTS-1:0]          wb_phyf_we;
  logic [WB_PORTS*PHY_ID_W-1:0] wb_phyf_id;
  logic [WB_PORTS*DATA_W-1:0]   wb_phyf_data;
  logic [WB_PORTS*ROB_ID_W-1:0] wb_rob_id;
  logic [WB_PORTS-1:0]          wb_exc;
  logic                         busy;

  modport master (
    output flush, in_valid, in_rd_we, in_exc, in_phy_id, in_data, in_rob_id,
    input  in_ready, wb_valid, wb_phyf_we, wb_phyf_id, wb_phyf_data,
           wb_rob_id, wb_exc, busy
  );

  modport slave (
    input  flush, in_valid, in_rd_we, in_exc, in_phy_id, in_data, in_rob_id,
    output in_ready, wb_valid, wb_phyf_we, wb_phyf_id, wb_phyf_data,
           wb_rob_id, wb_exc, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-channel result FIFOs drained by a round-robin arbiter onto
// WB_PORTS registered writeback ports. Flush discards everything buffered.
// Optional feature: define WB_ARBITER_BYPASS_EN to let a result arriving at
// an empty channel compete for a port in the same cycle (latency t+1).
module wb_arbiter #(
  parameter int IN_CH      = 6,
  parameter int WB_PORTS   = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int PHY_ID_W   = 6,
  parameter int DATA_W     = 32,
  parameter int ROB_ID_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;

  typedef struct packed {
    logic                rd_we;
    logic                exc;
    logic [PHY_ID_W-1:0] phy_id;
    logic [DATA_W-1:0]   data;
    logic [ROB_ID_W-1:0] rob_id;
  } entry_t;

  // Channel-side view shared with the arbiter
  entry_t           in_entry [IN_CH];
  entry_t           head     [IN_CH];
  logic [IN_CH-1:0] head_valid;
  logic [IN_CH-1:0] nonempty;
  logic [IN_CH-1:0] grant;

  // Arbiter results
  logic [WB_PORTS-1:0] port_used;
  logic [RR_W-1:0]     port_ch [WB_PORTS];
  logic [RR_W-1:0]     rr_ptr_reg;
  logic [RR_W-1:0]     rr_ptr_next;
  logic [RR_W-1:0]     last_ch;
  logic [RR_W:0]       scan_pos;
  logic [RR_W-1:0]     scan_ch;
  int                  n_grant;

  // ------------------------------------------------------------------
  // Per-channel circular FIFO
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < IN_CH; gi++) begin : g_ch
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;
    logic             bypass_take;

    assign in_entry[gi] = {bus.in_rd_we[gi],
                           bus.in_exc[gi],
                           bus.in_phy_id[gi*PHY_ID_W +: PHY_ID_W],
                           bus.in_data[gi*DATA_W +: DATA_W],
                           bus.in_rob_id[gi*ROB_ID_W +: ROB_ID_W]};

    assign nonempty[gi]     = (count_reg != '0);
    // Ready comes from the registered count only, so a full channel cannot
    // accept even when its head is being dequeued this cycle.
    assign bus.in_ready[gi] = (count_reg != CNT_W'(FIFO_DEPTH));

`ifdef WB_ARBITER_BYPASS_EN
    // An empty channel offers the incoming result as its head; a granted
    // bypass skips the FIFO, an ungranted one is enqueued normally.
    assign head_valid[gi]  = nonempty[gi] | bus.in_valid[gi];
    assign head[gi]        = nonempty[gi] ? mem[rd_ptr_reg] : in_entry[gi];
    assign bypass_take     = grant[gi] & ~nonempty[gi];
`else
    assign head_valid[gi]  = nonempty[gi];
    assign head[gi]        = mem[rd_ptr_reg];
    assign bypass_take     = 1'b0;
`endif

    assign pop  = grant[gi] & nonempty[gi];
    assign push = bus.in_valid[gi] & bus.in_ready[gi] & ~bus.flush & ~bypass_take;

    // Pointer and occupancy update; flush empties the channel
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else if (bus.flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
    end

    // Entry storage; contents are only meaningful below count_reg
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= in_entry[gi];
    end
  end

  // ------------------------------------------------------------------
  // Round-robin scan from rr_ptr, first WB_PORTS valid heads win,
  // assigned to ports in scan order
  // ------------------------------------------------------------------
  // Grant selection and next round-robin pointer
  always_comb begin
    grant       = '0;
    port_used   = '0;
    last_ch     = rr_ptr_reg;
    n_grant     = 0;
    scan_pos    = '0;
    scan_ch     = '0;
    for (int p = 0; p < WB_PORTS; p++) port_ch[p] = '0;

    for (int k = 0; k < IN_CH; k++) begin
      scan_pos = {1'b0, rr_ptr_reg} + (RR_W+1)'(k);
      if (scan_pos >= (RR_W+1)'(IN_CH)) scan_pos = scan_pos - (RR_W+1)'(IN_CH);
      scan_ch = scan_pos[RR_W-1:0];
      if (head_valid[scan_ch] && (n_grant < WB_PORTS)) begin
        grant[scan_ch] = 1'b1;
        for (int p = 0; p < WB_PORTS; p++) begin
          if (n_grant == p) begin
            port_used[p] = 1'b1;
            port_ch[p]   = scan_ch;
          end
        end
        last_ch = scan_ch;
        n_grant = n_grant + 1;
      end
    end

    rr_ptr_next = rr_ptr_reg;
    if (|grant) begin
      rr_ptr_next = (last_ch == RR_W'(IN_CH - 1)) ? '0 : last_ch + RR_W'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rr_ptr_reg <= '0;
    else if (bus.flush) rr_ptr_reg <= '0;
    else                rr_ptr_reg <= rr_ptr_next;
  end

  // ------------------------------------------------------------------
  // Registered writeback ports
  // ------------------------------------------------------------------
  for (genvar gp = 0; gp < WB_PORTS; gp++) begin : g_port
    entry_t              sel;
    logic                valid_reg;
    logic                we_reg;
    logic                exc_reg;
    logic [PHY_ID_W-1:0] id_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [ROB_ID_W-1:0] rob_reg;
    logic                load;

    assign sel  = head[port_ch[gp]];
    assign load = port_used[gp] & ~bus.flush;

    // Valid/enable pulse for one cycle per op; payload holds when idle
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_reg <= 1'b0;
        we_reg    <= 1'b0;
        exc_reg   <= 1'b0;
        id_reg    <= '0;
        data_reg  <= '0;
        rob_reg   <= '0;
      end else begin
        valid_reg <= load;
        // Exceptions and no-destination ops complete without a RF write
        we_reg    <= load & sel.rd_we & ~sel.exc;
        if (load) begin
          exc_reg  <= sel.exc;
          id_reg   <= sel.phy_id;
          data_reg <= sel.data;
          rob_reg  <= sel.rob_id;
        end
      end
    end

    assign bus.wb_valid[gp]                           = valid_reg;
    assign bus.wb_phyf_we[gp]                         = we_reg;
    assign bus.wb_exc[gp]                             = exc_reg;
    assign bus.wb_phyf_id[gp*PHY_ID_W +: PHY_ID_W]    = id_reg;
    assign bus.wb_phyf_data[gp*DATA_W +: DATA_W]      = data_reg;
    assign bus.wb_rob_id[gp*ROB_ID_W +: ROB_ID_W]     = rob_reg;
  end

  assign bus.busy = |nonempty;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised writeback arbiter between the execute units and the physical register file / commit stage. Each execute channel feeds a small per-channel FIFO with a valid/ready handshake. A round-robin arbiter drains up to WB_PORTS FIFO heads per cycle onto registered writeback ports, so more execute units than register-file write ports are supported without stalling the units combinationally. A commit-driven flush discards all buffered and in-flight results.

## Interface
- IN_CH, default 6: number of execute input channels (≥1).
- WB_PORTS, default 4: number of writeback output ports (1..IN_CH).
- FIFO_DEPTH, default 2: entries per channel FIFO (power of two, ≥2).
- PHY_ID_W, default 6: physical register id width.
- DATA_W, default 32: result data width.
- ROB_ID_W, default 5: ROB id width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous flush (commit feedback enable & flush).
- in_valid  in  IN_CH  channel i presents a result.
- in_ready  out  IN_CH  channel i FIFO not full; transfer when in_valid[i] & in_ready[i].
- in_rd_we  in  IN_CH  result writes a renamed destination.
- in_exc  in  IN_CH  result carries an exception.
- in_phy_id  in  IN_CH*PHY_ID_W  destination physical register; channel i at slice i.
- in_data  in  IN_CH*DATA_W  result value.
- in_rob_id  in  IN_CH*ROB_ID_W  ROB entry id.
- wb_valid  out  WB_PORTS  port p carries a completed op (commit completion).
- wb_phyf_we  out  WB_PORTS  register-file/feedback write enable.
- wb_phyf_id  out  WB_PORTS*PHY_ID_W  write id.
- wb_phyf_data  out  WB_PORTS*DATA_W  write data.
- wb_rob_id  out  WB_PORTS*ROB_ID_W  ROB id of the completed op.
- wb_exc  out  WB_PORTS  exception flag of the completed op.
- busy  out  1  any FIFO non-empty.

## Operation
- Per channel: circular FIFO with read/write pointers plus a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH. in_ready[i] = (count[i] != FIFO_DEPTH); it does not depend on in_valid or grants, and never depends combinationally on flush.
- Arbitration, each cycle: scan the channels starting at rr_ptr, in order rr_ptr, rr_ptr+1, … mod IN_CH. Grant the first min(WB_PORTS, non-empty count) non-empty channels, at most one entry per channel. Grants map to ports 0, 1, … in scan order.
- A granted head is dequeued at the edge. Port registers load: wb_valid=1, wb_phyf_we = rd_we & ~exc, plus id/data/rob_id/exc. Ungranted ports load wb_valid=0 and wb_phyf_we=0; their data fields hold their previous values.
- rr_ptr update: if any grant occurred, rr_ptr becomes (last granted channel + 1) mod IN_CH; otherwise it is unchanged.
- Simultaneous enqueue and dequeue on a full channel: in_ready is still 0 that cycle (registered count), so no enqueue occurs. On a non-full channel, enqueue and dequeue in the same cycle leave count unchanged.
- Exception results and results with in_rd_we=0 still consume a port so that the op completes in the ROB.
- flush=1 at an edge:
  - all counts and pointers go to 0;
  - rr_ptr goes to 0;
  - all wb_valid and wb_phyf_we go to 0;
  - an input handshaken in the same cycle is discarded;
  - no grant that cycle reaches the outputs.
- Reset (rst=0, async): counts, pointers and rr_ptr = 0; wb_valid, wb_phyf_we, wb_exc = 0; id/data/rob_id outputs = 0; busy = 0; in_ready = all ones after release. Reset mid-operation drops all buffered results.

## Timing
- Outputs are registered: a result handshaken in cycle t is visible on the ports in cycle t+2 at minimum. Each cycle of contention adds 1 cycle.
- A write port is held for exactly one cycle per completed op. There is no back-pressure from the downstream side.
- Worst-case wait for a non-empty channel: ceil(IN_CH/WB_PORTS) cycles of arbitration.
- busy and in_ready are functions of registered state only.

## Configuration
- WB_ARBITER_BYPASS_EN defined: when a channel FIFO is empty and in_valid[i]=1, the arbiter treats the incoming result as that channel's head. If granted, it goes straight to the port registers without being written into the FIFO, so minimum latency is t+1. If not granted, it is enqueued as normal. in_ready is unchanged. Flush still discards a bypassing result.
- WB_ARBITER_BYPASS_EN undefined: arbitration sees FIFO heads only, and minimum latency is t+2.

## Test plan
- Single op: IN_CH=6, WB_PORTS=4. Channel 2 sends phy=5, data=0xDEAD_BEEF, rob=3, rd_we=1 in cycle 0 -> in cycle 2, port 0 shows wb_valid=1, wb_phyf_we=1, id=5, data=0xDEADBEEF, rob=3; rr_ptr=3. With bypass: same outputs in cycle 1.
- Contention: all 6 channels send one op in cycle 0, rr_ptr=0 -> cycle 2: ports 0..3 carry channels 0..3. Cycle 3: ports 0..1 carry channels 4,5; ports 2,3 have wb_valid=0; rr_ptr=0.
- Full FIFO: channel 1 pushes 3 ops back to back while its grants are blocked (channels 2..5 hold the ports with WB_PORTS=1, rr_ptr=2) -> in_ready[1]=0 after 2 accepts; the third op is held by the sender. No op is lost or duplicated.
- Exception / no-rd: op with exc=1, rd_we=1 -> wb_valid=1, wb_exc=1, wb_phyf_we=0. Op with rd_we=0 -> wb_valid=1, wb_phyf_we=0.
- Flush: 4 channels hold 2 entries each; flush=1 in cycle 5 together with a new handshake on channel 0 -> cycle 6: all wb_valid=0, busy=0, in_ready all 1. The channel-0 op never appears.
- Async reset: assert rst=0 mid-burst between edges -> outputs go to 0 immediately. After release, a new op follows the t+2 latency with rr_ptr=0.
